alu_wb_stage: RTL

//  Write-back stage directly downstream of the cpu2 ALU. Accepts ALU results (res, fo, wb_en,

---
 rtl/alu_wb_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU write-back stage: flag register plus register-write queue
// Optional operand forwarding from queued writes: define ALU_WB_FWD_EN.
module alu_wb_stage #(
  parameter int WIDTH = 32,
  parameter int RW    = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RW-1:0]            in_rd,
  input  logic [WIDTH-1:0]         in_res,
  input  logic [WIDTH-1:0]         in_fo,
  input  logic                     in_wb_en,
  input  logic                     in_flag_en,
  output logic [WIDTH-1:0]         flags_q,
  output logic                     rf_we,
  output logic [RW-1:0]            rf_wa,
  output logic [WIDTH-1:0]         rf_wd,
  input  logic                     rf_ack,
  input  logic [RW-1:0]            fwd_ra,
  output logic                     fwd_hit,
  output logic [WIDTH-1:0]         fwd_data,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [RW-1:0]    addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             accept;
  logic             push;
  logic             pop;

  // Readiness looks only at occupancy, so a full queue never accepts even when popping.
  assign in_ready = (q_count < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign push     = accept & in_wb_en;
  assign rf_we    = (q_count != '0);
  assign pop      = rf_we & rf_ack;
  assign rf_wa    = addr_mem[rd_ptr];
  assign rf_wd    = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      flags_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (accept && in_flag_en) begin
        flags_q <= in_fo;
      end
      if (push) begin
        addr_mem[wr_ptr] <= in_rd;
        data_mem[wr_ptr] <= in_res;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

`ifdef ALU_WB_FWD_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < q_count) && (addr_mem[idx] == fwd_ra)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end
`else
  logic unused_fwd_ra;

  assign unused_fwd_ra = ^fwd_ra;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule
